// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control slice.
// Optional illegal-funct detection is enabled by ALU_CTRL_ILLEGAL_EN.
package alu_ctrl_pkg;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_SLTU = 4'b1000;
  localparam logic [3:0] SEL_NOR  = 4'b1100;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } md_state_t;

endpackage

// File: rtl/alu_control_mc_md_sequencer.sv
// Mul/div sequencer: IDLE -> RUN (MD_CYCLES) -> DONE (HI/LO write).
// Owns the iteration counter and the latched op attributes.
module md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic op_signed,
  input  logic op_div,
  output logic md_start,
  output logic md_signed,
  output logic md_is_div,
  output logic md_busy,
  output logic hilo_we
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MD_CYCLES - 1);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sgn_n, div_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      md_signed <= 1'b0;
      md_is_div <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      md_signed <= sgn_n;
      md_is_div <= div_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sgn_n    = md_signed;
    div_n    = md_is_div;
    md_start = 1'b0;
    hilo_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          md_start = 1'b1;
          sgn_n    = op_signed;
          div_n    = op_div;
          cnt_n    = CNT_LOAD;
          state_n  = RUN;
        end
      end
      RUN: begin
        // Hold at zero so the counter can never wrap.
        if (cnt == '0) state_n = DONE;
        else cnt_n = cnt - 1'b1;
      end
      DONE: begin
        hilo_we = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      md_start = 1'b0;
      hilo_we  = 1'b0;
    end
  end

  assign md_busy = (state != IDLE);

endmodule

// File: rtl/alu_control_mc.sv
// EX-stage ALU control: select decode, HI/LO stall, mul/div launch.
// Define ALU_CTRL_ILLEGAL_EN to add the illegal-funct output.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter int FUNCT_W   = 6,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               flush,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [SEL_W-1:0]   select,
  output logic               md_start,
  output logic               md_signed,
  output logic               md_is_div,
  output logic               md_busy,
  output logic               hilo_we,
  output logic               stall
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic               illegal
`endif
);

  localparam logic [SEL_W-1:0] PASS = SEL_W'(SEL_PASS);

  logic             op_add, op_sub, op_r, op_or;
  logic             f_md, f_mf, live, accept;
  logic [SEL_W-1:0] r_sel, sel_n;

  assign op_add = (alu_op == ALU_OP_ADD);
  assign op_sub = (alu_op == ALU_OP_SUB);
  assign op_r   = (alu_op == ALU_OP_RTYPE);
  assign op_or  = (alu_op == ALU_OP_OR);

  assign f_md = (funct == FUNCT_W'(FUNCT_MULT))
              | (funct == FUNCT_W'(FUNCT_MULTU))
              | (funct == FUNCT_W'(FUNCT_DIV))
              | (funct == FUNCT_W'(FUNCT_DIVU));
  assign f_mf = (funct == FUNCT_W'(FUNCT_MFHI))
              | (funct == FUNCT_W'(FUNCT_MFLO));

  always_comb begin
    r_sel = PASS;
    case (funct)
      FUNCT_W'(FUNCT_ADD),
      FUNCT_W'(FUNCT_ADDU): r_sel = SEL_W'(SEL_ADD);
      FUNCT_W'(FUNCT_SUB),
      FUNCT_W'(FUNCT_SUBU): r_sel = SEL_W'(SEL_SUB);
      FUNCT_W'(FUNCT_AND):  r_sel = SEL_W'(SEL_AND);
      FUNCT_W'(FUNCT_OR):   r_sel = SEL_W'(SEL_OR);
      FUNCT_W'(FUNCT_XOR):  r_sel = SEL_W'(SEL_XOR);
      FUNCT_W'(FUNCT_NOR):  r_sel = SEL_W'(SEL_NOR);
      FUNCT_W'(FUNCT_SLT):  r_sel = SEL_W'(SEL_SLT);
      FUNCT_W'(FUNCT_SLTU): r_sel = SEL_W'(SEL_SLTU);
      default:              r_sel = PASS;
    endcase
  end

  always_comb begin
    sel_n = PASS;
    unique case (1'b1)
      op_add:  sel_n = SEL_W'(SEL_ADD);
      op_sub:  sel_n = SEL_W'(SEL_SUB);
      op_or:   sel_n = SEL_W'(SEL_OR);
      op_r:    sel_n = r_sel;
      default: sel_n = PASS;
    endcase
    if (rst) sel_n = PASS;
  end

  assign select = sel_n;

  // Only HI/LO consumers wait on the unit; plain ALU ops flow.
  assign live   = valid & ~flush;
  assign stall  = ~rst & md_busy & live
                & op_r & (f_md | f_mf);
  assign accept = live & ~stall & op_r & f_md;

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = ~rst & live & op_r
                 & (r_sel == PASS) & ~f_md & ~f_mf;
`endif

  md_sequencer #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .op_signed (~funct[0]),
    .op_div    (funct[1]),
    .md_start  (md_start),
    .md_signed (md_signed),
    .md_is_div (md_is_div),
    .md_busy   (md_busy),
    .hilo_we   (hilo_we)
  );

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc with a cycle-level reference model.
// Build with ALU_CTRL_ILLEGAL_EN to also check the illegal output.
module tb_alu_control_mc;

  localparam int MD = 4;

  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] ADD   = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] select;
  logic       md_start, md_signed, md_is_div;
  logic       md_busy, hilo_we, stall;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_control_mc #(
    .SEL_W     (4),
    .FUNCT_W   (6),
    .MD_CYCLES (MD),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .flush     (flush),
    .alu_op    (alu_op),
    .funct     (funct),
    .select    (select),
    .md_start  (md_start),
    .md_signed (md_signed),
    .md_is_div (md_is_div),
    .md_busy   (md_busy),
    .hilo_we   (hilo_we),
    .stall     (stall)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_sel(
    input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (f)
      6'h20, 6'h21: return 4'b0010;
      6'h22, 6'h23: return 4'b0110;
      6'h24:        return 4'b0000;
      6'h25:        return 4'b0001;
      6'h26:        return 4'b0011;
      6'h27:        return 4'b1100;
      6'h2a:        return 4'b0111;
      6'h2b:        return 4'b1000;
      default:      return 4'b1111;
    endcase
  endfunction

  // Reference model: tracks the start cycle of the op in flight.
  bit running = 0;
  int start_cyc = 0;
  bit m_sgn = 0;
  bit m_div = 0;

  always @(negedge clk) begin
    bit r, md_f, hl_f, e_stall, e_start, e_hwe;
    r    = (alu_op == 2'b10);
    md_f = r && (funct inside {MULT, MULTU, DIV, DIVU});
    hl_f = md_f || (r && (funct inside {6'h10, 6'h12}));
    if (rst) begin
      chk("m_rst_select", select, 4'hf);
      chk("m_rst_stall", stall, 0);
      chk("m_rst_start", md_start, 0);
      chk("m_rst_hilo_we", hilo_we, 0);
`ifdef ALU_CTRL_ILLEGAL_EN
      chk("m_rst_illegal", illegal, 0);
`endif
      running = 0;
      m_sgn = 0;
      m_div = 0;
    end else begin
      e_stall = running && valid && !flush && hl_f;
      e_start = !running && valid && !flush && md_f;
      e_hwe   = running && (cyc == start_cyc + MD + 1);
      chk("m_select", select, exp_sel(alu_op, funct));
      chk("m_stall", stall, e_stall);
      chk("m_start", md_start, e_start);
      chk("m_hilo_we", hilo_we, e_hwe);
      chk("m_busy", md_busy, running);
      chk("m_signed", md_signed, m_sgn);
      chk("m_is_div", md_is_div, m_div);
`ifdef ALU_CTRL_ILLEGAL_EN
      chk("m_illegal", illegal,
          valid && !flush && r && !hl_f &&
          exp_sel(alu_op, funct) == 4'hf);
`endif
      if (e_hwe) running = 0;
      if (e_start) begin
        running   = 1;
        start_cyc = cyc;
        m_sgn     = (funct == MULT) || (funct == DIV);
        m_div     = (funct == DIV) || (funct == DIVU);
      end
    end
  end

  task automatic step(input logic r, input logic v,
                      input logic fl, input logic [1:0] op,
                      input logic [5:0] fn);
    @(posedge clk);
    #1;
    rst = r; valid = v; flush = fl;
    alu_op = op; funct = fn;
    @(negedge clk);
  endtask

  logic [5:0] sw_f [11] = '{6'h20, 6'h21, 6'h22, 6'h23,
    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
  logic [3:0] sw_s [11] = '{4'h2, 4'h2, 4'h6, 4'h6,
    4'h0, 4'h1, 4'h3, 4'hc, 4'h7, 4'h8, 4'hf};

  initial begin
    step(1, 0, 0, 2'b00, 6'h00);
    chk("rst_select_pass", select, 4'hf);
    step(1, 1, 0, 2'b10, MULT);
    chk("rst_no_start", md_start, 0);

    step(0, 0, 0, 2'b00, 6'h2a);
    chk("post_rst_busy", md_busy, 0);
    chk("post_rst_hilo", hilo_we, 0);
    chk("post_rst_signed", md_signed, 0);
    chk("post_rst_is_div", md_is_div, 0);
    chk("op00_add", select, 4'b0010);
    step(0, 1, 0, 2'b01, 6'h24);
    chk("op01_sub", select, 4'b0110);
    step(0, 1, 0, 2'b11, 6'h3f);
    chk("op11_or", select, 4'b0001);

    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, 2'b10, sw_f[i]);
      chk("funct_sweep", select, sw_s[i]);
`ifdef ALU_CTRL_ILLEGAL_EN
      chk("illegal_sweep", illegal, (i == 10));
`endif
    end

    // MULT timing
    step(0, 1, 0, 2'b10, MULT);
    chk("mult_start", md_start, 1);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 2'b00, 6'h00);
      chk("mult_busy", md_busy, (k <= 5));
      chk("mult_hilo_we", hilo_we, (k == 5));
      if (k <= 5) begin
        chk("mult_signed", md_signed, 1);
        chk("mult_is_div", md_is_div, 0);
      end
    end

    // DIVU, then ADD flows, then MFLO waits
    step(0, 1, 0, 2'b10, DIVU);
    chk("divu_start", md_start, 1);
    step(0, 1, 0, 2'b10, ADD);
    chk("add_no_stall", stall, 0);
    chk("add_select", select, 4'b0010);
    for (int k = 2; k <= 5; k++) begin
      step(0, 1, 0, 2'b10, MFLO);
      chk("mflo_stall", stall, 1);
      chk("mflo_hilo_we", hilo_we, (k == 5));
    end
    step(0, 1, 0, 2'b10, MFLO);
    chk("mflo_go", stall, 0);
    chk("mflo_idle", md_busy, 0);

    // DIV then MULTU back-to-back
    step(0, 1, 0, 2'b10, DIV);
    chk("div_start", md_start, 1);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0, 2'b10, MULTU);
      chk("b2b_stall", stall, 1);
      chk("b2b_no_start", md_start, 0);
    end
    step(0, 1, 0, 2'b10, MULTU);
    chk("b2b_go", stall, 0);
    chk("b2b_start", md_start, 1);
    step(0, 0, 0, 2'b00, 6'h00);
    chk("multu_busy", md_busy, 1);
    chk("multu_signed", md_signed, 0);
    chk("multu_is_div", md_is_div, 0);
    for (int k = 8; k <= 12; k++) begin
      step(0, 0, 0, 2'b00, 6'h00);
      chk("multu_hilo_we", hilo_we, (k == 11));
    end

    // flush during RUN does not abort
    step(0, 1, 0, 2'b10, MULT);
    chk("fl_run_start", md_start, 1);
    step(0, 1, 1, 2'b10, MULT);
    chk("fl_run_stall", stall, 0);
    for (int k = 2; k <= 6; k++) begin
      step(0, 0, 0, 2'b00, 6'h00);
      chk("fl_run_hilo_we", hilo_we, (k == 5));
    end

    // rst mid-RUN
    step(0, 1, 0, 2'b10, DIV);
    chk("rr_start", md_start, 1);
    step(0, 0, 0, 2'b00, 6'h00);
    chk("rr_busy", md_busy, 1);
    step(1, 0, 0, 2'b00, 6'h00);
    chk("rr_hilo_in_rst", hilo_we, 0);
    step(0, 0, 0, 2'b00, 6'h00);
    chk("rr_idle", md_busy, 0);
    chk("rr_is_div", md_is_div, 0);
    chk("rr_signed", md_signed, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 2'b00, 6'h00);
      chk("rr_no_hilo", hilo_we, 0);
    end

    // flush on a mul/div in IDLE
    step(0, 1, 1, 2'b10, MULT);
    chk("flush_no_start", md_start, 0);
    step(0, 0, 0, 2'b00, 6'h00);
    chk("flush_idle", md_busy, 0);

    step(0, 0, 0, 2'b00, 6'h00);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
